// File: rtl/npc_csr_pkg.sv
// Shared definitions for the machine-mode CSR slice: CSR addresses, trap cause
// codes, mstatus bit positions and the trap responder state encoding.
package npc_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CSR_COUNT       = 4;
    localparam int CSR_IDX_MSTATUS = 0;
    localparam int CSR_IDX_MTVEC   = 1;
    localparam int CSR_IDX_MEPC    = 2;
    localparam int CSR_IDX_MCAUSE  = 3;

    // Entry gi holds the address of the CSR with index gi above.
    localparam logic [CSR_COUNT-1:0][11:0] CSR_ADDR_TABLE =
        {CSR_MCAUSE, CSR_MEPC, CSR_MTVEC, CSR_MSTATUS};

    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // MPP is hardwired to M-mode; only MIE and MPIE are stored.
    localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;
    localparam logic [31:0] ALIGN4_MASK      = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_REDIRECT
    } resp_state_t;

    function automatic logic [31:0] mstatus_view(input logic mie, input logic mpie);
        logic [31:0] v;
        v                   = MSTATUS_MPP_BITS;
        v[MSTATUS_MIE_BIT]  = mie;
        v[MSTATUS_MPIE_BIT] = mpie;
        return v;
    endfunction

endpackage

// File: rtl/trap_responder_if.sv
// Bundle between the WB stage / front end / CSR instruction path and the trap
// responder; slave is the responder side, master the pipeline side.
interface trap_responder_if;
    logic        trap_req;
    logic        trap_is_ebreak;
    logic [31:0] trap_pc;
    logic        mret_req;
    logic        trap_ack;
    logic        mret_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport slave (
        input  trap_req, trap_is_ebreak, trap_pc, mret_req, redirect_ready,
        input  csr_we, csr_addr, csr_wdata,
        output trap_ack, mret_ack, redirect_valid, redirect_pc, busy, csr_rdata
    );

    modport master (
        output trap_req, trap_is_ebreak, trap_pc, mret_req, redirect_ready,
        output csr_we, csr_addr, csr_wdata,
        input  trap_ack, mret_ack, redirect_valid, redirect_pc, busy, csr_rdata
    );
endinterface

// File: rtl/trap_responder_csr_file.sv
// Machine-mode CSRs (mstatus, mtvec, mepc, mcause) with a software CSRRW port
// and a hardware port for trap entry and MRET; hardware updates beat software.
module csr_file
    import npc_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_we,
    input  logic [11:0] sw_addr,
    input  logic [31:0] sw_wdata,
    output logic [31:0] rdata,
    input  logic        hw_trap_save,
    input  logic [31:0] hw_trap_pc,
    input  logic [31:0] hw_trap_cause,
    input  logic        hw_mret,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic            mie_reg;
    logic            mpie_reg;
    logic [31:0]     mtvec_reg;
    logic [31:0]     mepc_reg;
    logic [31:0]     mcause_reg;
    logic [CSR_COUNT-1:0] addr_hit;
    logic [CSR_COUNT-1:0] sw_wr;

    generate
        for (genvar gi = 0; gi < CSR_COUNT; gi++) begin : g_decode
            assign addr_hit[gi] = (sw_addr == CSR_ADDR_TABLE[gi]);
            assign sw_wr[gi]    = sw_we && addr_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_reg    <= 1'b0;
            mpie_reg   <= 1'b0;
            mtvec_reg  <= '0;
            mepc_reg   <= '0;
            mcause_reg <= '0;
        end else begin
            if (hw_trap_save) begin
                mpie_reg <= mie_reg;
                mie_reg  <= 1'b0;
            end else if (hw_mret) begin
                mie_reg  <= mpie_reg;
                mpie_reg <= 1'b1;
            end else if (sw_wr[CSR_IDX_MSTATUS]) begin
                mie_reg  <= sw_wdata[MSTATUS_MIE_BIT];
                mpie_reg <= sw_wdata[MSTATUS_MPIE_BIT];
            end

            if (sw_wr[CSR_IDX_MTVEC]) begin
                mtvec_reg <= sw_wdata & ALIGN4_MASK;
            end

            if (hw_trap_save) begin
                mepc_reg <= hw_trap_pc & ALIGN4_MASK;
            end else if (sw_wr[CSR_IDX_MEPC]) begin
                mepc_reg <= sw_wdata & ALIGN4_MASK;
            end

            if (hw_trap_save) begin
                mcause_reg <= hw_trap_cause;
            end else if (sw_wr[CSR_IDX_MCAUSE]) begin
                mcause_reg <= sw_wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr_hit[CSR_IDX_MSTATUS]) begin
            rdata = mstatus_view(mie_reg, mpie_reg);
        end else if (addr_hit[CSR_IDX_MTVEC]) begin
            rdata = mtvec_reg;
        end else if (addr_hit[CSR_IDX_MEPC]) begin
            rdata = mepc_reg;
        end else if (addr_hit[CSR_IDX_MCAUSE]) begin
            rdata = mcause_reg;
        end
    end

    assign mtvec = mtvec_reg;
    assign mepc  = mepc_reg;

endmodule

// File: rtl/trap_responder.sv
// Trap entry / MRET sequencer: acks ECALL, EBREAK and MRET from WB, updates the
// machine CSRs and issues a single redirect to the front end.
module trap_responder
    import npc_csr_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    trap_responder_if.slave bus
);

    resp_state_t state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] target_reg, target_next;
    logic        trap_take;
    logic        mret_take;
    logic        save_active;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    assign save_active = (state_reg == ST_SAVE);

    csr_file u_csr_file (
        .clk           (clk),
        .rst           (rst),
        .sw_we         (bus.csr_we),
        .sw_addr       (bus.csr_addr),
        .sw_wdata      (bus.csr_wdata),
        .rdata         (bus.csr_rdata),
        .hw_trap_save  (save_active),
        .hw_trap_pc    (pc_reg),
        .hw_trap_cause (cause_reg),
        .hw_mret       (mret_take),
        .mtvec         (mtvec),
        .mepc          (mepc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            cause_reg  <= '0;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            cause_reg  <= cause_next;
            target_reg <= target_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        cause_next  = cause_reg;
        target_next = target_reg;
        trap_take   = 1'b0;
        mret_take   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                // A trap beats a simultaneous MRET; the MRET stays pending.
                if (!rst && bus.trap_req) begin
                    trap_take  = 1'b1;
                    pc_next    = bus.trap_pc;
                    cause_next = bus.trap_is_ebreak ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
                    state_next = ST_SAVE;
                end else if (!rst && bus.mret_req) begin
                    mret_take   = 1'b1;
                    target_next = mepc;
                    state_next  = ST_REDIRECT;
                end
            end
            ST_SAVE: begin
                target_next = mtvec & ALIGN4_MASK;
                state_next  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are masked during reset so an abandoned operation never redirects.
    assign bus.trap_ack       = trap_take;
    assign bus.mret_ack       = mret_take;
    assign bus.redirect_valid = (state_reg == ST_REDIRECT) && !rst;
    assign bus.redirect_pc    = bus.redirect_valid ? target_reg : '0;
    assign bus.busy           = (state_reg != ST_IDLE) && !rst;

endmodule

// File: tb/tb_trap_responder.sv
// Directed bench for trap_responder: table-driven CSR software-port vectors
// followed by cycle-by-cycle trap, MRET, backpressure and reset sequences.
module tb_trap_responder;
    import npc_csr_pkg::*;

    logic clk = 1'b0;
    logic rst;

    trap_responder_if bus();

    trap_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
        string       name;
    } csr_vec_t;

    csr_vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, actual, expected);
        end else begin
            $display("ok   %s = 0x%08h", name, actual);
        end
    endtask

    // Only called while csr_we is low, so moving csr_addr cannot redirect a write.
    task automatic expect_csr(input string name, input logic [11:0] addr, input logic [31:0] expected);
        bus.csr_addr = addr;
        #1;
        check(name, bus.csr_rdata, expected);
    endtask

    task automatic sw_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.csr_we    = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_wdata = data;
        @(negedge clk);
        bus.csr_we    = 1'b0;
    endtask

    task automatic cycle_start();
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b1, CSR_MSTATUS, 32'hFFFF_FFFF, CSR_MSTATUS, 32'h0000_1888, "mstatus all ones"};
        vecs[1]  = '{1'b1, CSR_MSTATUS, 32'h0000_0080, CSR_MSTATUS, 32'h0000_1880, "mstatus mpie only"};
        vecs[2]  = '{1'b1, CSR_MSTATUS, 32'h0000_0000, CSR_MSTATUS, 32'h0000_1800, "mstatus zero"};
        vecs[3]  = '{1'b1, CSR_MTVEC,   32'h8000_0103, CSR_MTVEC,   32'h8000_0100, "mtvec low bits"};
        vecs[4]  = '{1'b1, CSR_MEPC,    32'h1234_5677, CSR_MEPC,    32'h1234_5674, "mepc low bits"};
        vecs[5]  = '{1'b1, CSR_MCAUSE,  32'hDEAD_BEEF, CSR_MCAUSE,  32'hDEAD_BEEF, "mcause write"};
        vecs[6]  = '{1'b1, 12'h340,     32'hFFFF_FFFF, 12'h340,     32'h0000_0000, "unimpl reads 0"};
        vecs[7]  = '{1'b1, 12'h343,     32'h0000_0001, CSR_MCAUSE,  32'hDEAD_BEEF, "unimpl no alias"};
        vecs[8]  = '{1'b0, CSR_MEPC,    32'hFFFF_FFFF, CSR_MEPC,    32'h1234_5674, "mepc we low"};
        vecs[9]  = '{1'b1, CSR_MEPC,    32'h0000_0000, CSR_MEPC,    32'h0000_0000, "mepc clear"};
        vecs[10] = '{1'b1, CSR_MCAUSE,  32'h0000_0000, CSR_MCAUSE,  32'h0000_0000, "mcause clear"};

        rst                = 1'b1;
        bus.trap_req       = 1'b0;
        bus.trap_is_ebreak = 1'b0;
        bus.trap_pc        = '0;
        bus.mret_req       = 1'b0;
        bus.redirect_ready = 1'b0;
        bus.csr_we         = 1'b0;
        bus.csr_addr       = '0;
        bus.csr_wdata      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst trap_ack", {31'd0, bus.trap_ack}, 32'd0);
        check("rst mret_ack", {31'd0, bus.mret_ack}, 32'd0);
        check("rst redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst redirect_pc", bus.redirect_pc, 32'd0);
        expect_csr("rst mstatus", CSR_MSTATUS, 32'h0000_1800);
        expect_csr("rst mtvec", CSR_MTVEC, 32'd0);
        expect_csr("rst mepc", CSR_MEPC, 32'd0);
        expect_csr("rst mcause", CSR_MCAUSE, 32'd0);

        // Software CSR port vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.csr_we    = vecs[i].we;
            bus.csr_addr  = vecs[i].waddr;
            bus.csr_wdata = vecs[i].wdata;
            @(negedge clk);
            bus.csr_we = 1'b0;
            expect_csr(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // ECALL: ack at cycle 0, redirect from cycle 2
        sw_write(CSR_MTVEC, 32'h8000_0100);
        bus.redirect_ready = 1'b1;
        cycle_start();
        bus.trap_req = 1'b1; bus.trap_is_ebreak = 1'b0; bus.trap_pc = 32'h8000_0044;
        #1;
        check("ecall c0 trap_ack", {31'd0, bus.trap_ack}, 32'd1);
        cycle_start();
        bus.trap_req = 1'b0;
        #1;
        check("ecall c1 trap_ack", {31'd0, bus.trap_ack}, 32'd0);
        check("ecall c1 redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("ecall c1 busy", {31'd0, bus.busy}, 32'd1);
        cycle_start();
        #1;
        check("ecall c2 redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("ecall c2 redirect_pc", bus.redirect_pc, 32'h8000_0100);
        expect_csr("ecall mepc", CSR_MEPC, 32'h8000_0044);
        expect_csr("ecall mcause", CSR_MCAUSE, 32'd11);
        expect_csr("ecall mstatus", CSR_MSTATUS, 32'h0000_1800);
        cycle_start();
        #1;
        check("ecall c3 busy", {31'd0, bus.busy}, 32'd0);
        check("ecall c3 redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);

        // EBREAK with MIE=1, then MRET
        sw_write(CSR_MSTATUS, 32'h0000_0008);
        cycle_start();
        bus.trap_req = 1'b1; bus.trap_is_ebreak = 1'b1; bus.trap_pc = 32'h8000_0010;
        #1;
        check("ebreak c0 trap_ack", {31'd0, bus.trap_ack}, 32'd1);
        cycle_start();
        bus.trap_req = 1'b0; bus.trap_is_ebreak = 1'b0;
        cycle_start();
        #1;
        check("ebreak c2 redirect_pc", bus.redirect_pc, 32'h8000_0100);
        expect_csr("ebreak mcause", CSR_MCAUSE, 32'd3);
        expect_csr("ebreak mstatus", CSR_MSTATUS, 32'h0000_1880);
        expect_csr("ebreak mepc", CSR_MEPC, 32'h8000_0010);
        cycle_start();
        bus.mret_req = 1'b1;
        #1;
        check("mret c0 mret_ack", {31'd0, bus.mret_ack}, 32'd1);
        check("mret c0 trap_ack", {31'd0, bus.trap_ack}, 32'd0);
        cycle_start();
        bus.mret_req = 1'b0;
        #1;
        check("mret c1 redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("mret c1 redirect_pc", bus.redirect_pc, 32'h8000_0010);
        expect_csr("mret mstatus", CSR_MSTATUS, 32'h0000_1888);
        cycle_start();
        #1;
        check("mret c2 busy", {31'd0, bus.busy}, 32'd0);

        // Trap and MRET together: trap wins, MRET acked after the redirect
        cycle_start();
        bus.trap_req = 1'b1; bus.mret_req = 1'b1; bus.trap_pc = 32'h8000_0047;
        #1;
        check("both c0 trap_ack", {31'd0, bus.trap_ack}, 32'd1);
        check("both c0 mret_ack", {31'd0, bus.mret_ack}, 32'd0);
        cycle_start();
        bus.trap_req = 1'b0;
        #1;
        check("both c1 mret_ack", {31'd0, bus.mret_ack}, 32'd0);
        cycle_start();
        #1;
        check("both c2 mret_ack", {31'd0, bus.mret_ack}, 32'd0);
        check("both c2 redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        expect_csr("both mepc aligned", CSR_MEPC, 32'h8000_0044);
        expect_csr("both mstatus", CSR_MSTATUS, 32'h0000_1880);
        cycle_start();
        #1;
        check("both c3 mret_ack", {31'd0, bus.mret_ack}, 32'd1);
        cycle_start();
        bus.mret_req = 1'b0;
        #1;
        check("both c4 redirect_pc", bus.redirect_pc, 32'h8000_0044);
        expect_csr("both c4 mstatus", CSR_MSTATUS, 32'h0000_1888);
        cycle_start();
        #1;
        check("both c5 busy", {31'd0, bus.busy}, 32'd0);

        // Backpressure: mtvec write and pending MRET while REDIRECT waits
        bus.redirect_ready = 1'b0;
        cycle_start();
        bus.trap_req = 1'b1; bus.trap_pc = 32'h8000_0200;
        #1;
        check("bp c0 trap_ack", {31'd0, bus.trap_ack}, 32'd1);
        cycle_start();
        bus.trap_req  = 1'b0;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MEPC;
        bus.csr_wdata = 32'h1111_1110;
        for (int k = 0; k < 5; k++) begin
            cycle_start();
            bus.csr_we = 1'b0;
            if (k == 0) bus.mret_req = 1'b1;
            if (k == 1) begin
                bus.csr_we    = 1'b1;
                bus.csr_addr  = CSR_MTVEC;
                bus.csr_wdata = 32'h9000_0000;
            end
            #1;
            check($sformatf("bp wait%0d redirect_valid", k), {31'd0, bus.redirect_valid}, 32'd1);
            check($sformatf("bp wait%0d redirect_pc", k), bus.redirect_pc, 32'h8000_0100);
            check($sformatf("bp wait%0d busy", k), {31'd0, bus.busy}, 32'd1);
            check($sformatf("bp wait%0d mret_ack", k), {31'd0, bus.mret_ack}, 32'd0);
        end
        cycle_start();
        bus.mret_req       = 1'b0;
        bus.redirect_ready = 1'b1;
        #1;
        check("bp handshake redirect_pc", bus.redirect_pc, 32'h8000_0100);
        cycle_start();
        #1;
        check("bp idle busy", {31'd0, bus.busy}, 32'd0);
        check("bp idle redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        expect_csr("bp mepc hw wins", CSR_MEPC, 32'h8000_0200);
        expect_csr("bp mtvec", CSR_MTVEC, 32'h9000_0000);

        // Reset while in SAVE abandons the trap
        cycle_start();
        bus.trap_req = 1'b1; bus.trap_pc = 32'h8000_0300;
        #1;
        check("rstsave c0 trap_ack", {31'd0, bus.trap_ack}, 32'd1);
        cycle_start();
        bus.trap_req = 1'b0;
        rst = 1'b1;
        #1;
        check("rstsave c1 trap_ack", {31'd0, bus.trap_ack}, 32'd0);
        cycle_start();
        rst = 1'b0;
        #1;
        check("rstsave busy", {31'd0, bus.busy}, 32'd0);
        check("rstsave redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("rstsave redirect_pc", bus.redirect_pc, 32'd0);
        expect_csr("rstsave mepc", CSR_MEPC, 32'd0);
        expect_csr("rstsave mtvec", CSR_MTVEC, 32'd0);
        expect_csr("rstsave mstatus", CSR_MSTATUS, 32'h0000_1800);
        for (int k = 0; k < 2; k++) begin
            cycle_start();
            #1;
            check($sformatf("rstsave after%0d redirect_valid", k), {31'd0, bus.redirect_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
